// File: rtl/mux_2x1_simple_comb_pkg.sv
// Shared decode helpers for the 2:1 tree mux: branch naming and select-bit position.
// Data/command widths stay parameters of the mux itself; nothing width-specific lives here.
package mux_2x1_simple_comb_pkg;

    typedef enum logic {
        BR_LOW  = 1'b0,
        BR_HIGH = 1'b1
    } branch_e;

    localparam int unsigned SEL_BIT      = 0;
    localparam int unsigned NUM_BRANCHES = 2;

    function automatic branch_e decode_sel(input logic sel_bit);
        return sel_bit ? BR_HIGH : BR_LOW;
    endfunction

endpackage

// File: rtl/mux_2x1_simple_comb_pipe_reg.sv
// Pipeline cut for the mux output: W-bit register with synchronous active-high clear.
// Latency 1 cycle; no backpressure, a new word is captured every edge.
module mux_2x1_simple_comb_pipe_reg #(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign data_d = d_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mux_2x1_simple_comb.sv
// 2:1 valid-qualified data mux for NoC trees; invalid/disabled cycles drive zero data.
// Latency 0 (REG_OUT=0) or 1 cycle (REG_OUT=1); no handshake, consumers sample every cycle.
module mux_2x1_simple_comb
    import mux_2x1_simple_comb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int COMMMAND_WIDTH = 1,
    parameter int REG_OUT        = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_BRANCHES-1:0]     i_valid,
    input  logic [2*DATA_WIDTH-1:0]     i_data_bus,
    input  logic                        i_en,
    input  logic [COMMMAND_WIDTH-1:0]   i_cmd,
    output logic                        o_valid,
    output logic [DATA_WIDTH-1:0]       o_data_bus
);

    branch_e               sel;
    logic                  v_next;
    logic [DATA_WIDTH-1:0] d_sel;
    logic [DATA_WIDTH-1:0] d_next;

    // Only bit 0 of the command selects; wider command fields are carried by the tree but ignored here.
    logic unused_cmd;
    assign unused_cmd = ^i_cmd;

    always_comb begin
        sel    = decode_sel(i_cmd[SEL_BIT]);
        d_sel  = i_data_bus[DATA_WIDTH-1:0];
        v_next = i_en & i_valid[0];
        if (sel == BR_HIGH) begin
            d_sel  = i_data_bus[DATA_WIDTH +: DATA_WIDTH];
            v_next = i_en & i_valid[1];
        end
        d_next = v_next ? d_sel : {DATA_WIDTH{1'b0}};
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [DATA_WIDTH:0] pipe_q;

            mux_2x1_simple_comb_pipe_reg #(
                .W (DATA_WIDTH + 1)
            ) u_pipe_reg (
                .clk_i (clk),
                .rst_i (rst),
                .d_i   ({v_next, d_next}),
                .q_o   (pipe_q)
            );

            assign o_valid    = pipe_q[DATA_WIDTH];
            assign o_data_bus = pipe_q[DATA_WIDTH-1:0];
        end else begin : g_comb
            // Purely combinational: clock and reset have no effect in this mode.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign o_valid    = v_next;
            assign o_data_bus = d_next;
        end
    endgenerate

endmodule

// File: tb/tb_mux_2x1_simple_comb.sv
// Scoreboard bench: one combinational and one registered mux share random/directed stimulus.
module tb_mux_2x1_simple_comb;

    bit          clk;
    logic        rst;
    logic [1:0]  i_valid;
    logic [63:0] i_data_bus;
    logic        i_en;
    logic [0:0]  cmd_c;
    logic [1:0]  cmd_r;
    logic        ov_c, ov_r;
    logic [31:0] od_c, od_r;

    typedef struct {
        logic        v;
        logic [31:0] d;
    } exp_t;

    exp_t qc[$];
    exp_t qr[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mux_2x1_simple_comb #(.DATA_WIDTH(32), .COMMMAND_WIDTH(1), .REG_OUT(0)) dut_c (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .i_en(i_en),
        .i_cmd(cmd_c), .o_valid(ov_c), .o_data_bus(od_c)
    );

    mux_2x1_simple_comb #(.DATA_WIDTH(32), .COMMMAND_WIDTH(2), .REG_OUT(1)) dut_r (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .i_en(i_en),
        .i_cmd(cmd_r), .o_valid(ov_r), .o_data_bus(od_r)
    );

    // Reference: pick branch number from command LSB, shift the bus by 32*branch.
    function automatic exp_t model(input bit r, input bit en, input bit [1:0] valid,
                                   input bit [1:0] cmd, input bit [63:0] bus, input bit use_rst);
        exp_t e;
        int   s;
        s   = int'(cmd) % 2;
        e.v = 1'b0;
        e.d = 32'h0;
        if (!(use_rst && r) && en && (((int'(valid) >> s) % 2) == 1)) begin
            e.v = 1'b1;
            e.d = 32'((bus >> (32 * s)) & 64'h0000_0000_FFFF_FFFF);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic apply(input bit r, input bit en, input bit [1:0] valid,
                         input bit [1:0] cmd, input bit [63:0] bus);
        rst        = r;
        i_en       = en;
        i_valid    = valid;
        cmd_c      = cmd[0];
        cmd_r      = cmd;
        i_data_bus = bus;
        qc.push_back(model(r, en, valid, cmd, bus, 1'b0));
        qr.push_back(model(r, en, valid, cmd, bus, 1'b1));
    endtask

    // Monitor: comb output checked in the cycle it was driven, registered output one cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (qc.size() > 0) begin
            e = qc.pop_front();
            chk("comb_valid", 32'(ov_c), 32'(e.v));
            chk("comb_data", od_c, e.d);
        end
        if (qr.size() >= 2) begin
            e = qr.pop_front();
            chk("reg_valid", 32'(ov_r), 32'(e.v));
            chk("reg_data", od_r, e.d);
        end
    end

    localparam bit [63:0] BUS_FA = {32'hFFFF_FFFF, 32'hAAAA_AAAA};
    localparam bit [63:0] BUS_0F = {32'h0000_0000, 32'hFFFF_FFFF};

    initial begin
        // Value seen at the very first edge: reset asserted.
        rst        = 1'b1;
        i_en       = 1'b1;
        i_valid    = 2'b11;
        cmd_c      = 1'b1;
        cmd_r      = 2'b01;
        i_data_bus = BUS_FA;
        qr.push_back(model(1'b1, 1'b1, 2'b11, 2'b01, BUS_FA, 1'b1));

        @(posedge clk); #1 apply(1, 1, 2'b11, 2'b01, BUS_FA);
        @(posedge clk); #1 apply(0, 0, 2'b11, 2'b11, BUS_FA);
        @(posedge clk); #1 apply(0, 1, 2'b10, 2'b01, BUS_FA);
        @(posedge clk); #1 apply(0, 1, 2'b01, 2'b10, BUS_FA);
        @(posedge clk); #1 apply(0, 1, 2'b01, 2'b01, BUS_FA);
        @(posedge clk); #1 apply(0, 1, 2'b10, 2'b10, BUS_FA);
        @(posedge clk); #1 apply(0, 1, 2'b01, 2'b00, BUS_0F);
        @(posedge clk); #1 apply(0, 1, 2'b10, 2'b01, BUS_FA);
        @(posedge clk); #1 apply(1, 1, 2'b10, 2'b01, BUS_FA);
        @(posedge clk); #1 apply(0, 1, 2'b10, 2'b01, BUS_FA);
        @(posedge clk); #1 apply(0, 1, 2'b11, 2'b00, BUS_FA);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 apply(($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     {$urandom, $urandom});
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("comb_queue_drained", 32'(qc.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_2x1_simple_comb.md
Name: mux_2x1_simple_comb

Overview:
- 2-to-1 data-bus multiplexer with per-input valid qualification, a block enable and a select command.
- Used as a leaf switching element in the NoC distribution/reduction trees. Its default datapath is purely combinational.
- Carries no packet format. Data passes through unchanged, and idle/invalid cycles output the dummy value {DATA_WIDTH{1'b0}}.
- An optional output register stage (REG_OUT) lets tree builders insert pipeline cuts at the mux boundary.

Parameters:
- DATA_WIDTH, 32, width of each data branch and of the output.
- COMMMAND_WIDTH, 1, width of i_cmd. Only bit 0 is decoded; higher bits are ignored.
- REG_OUT, 0. 0 = combinational output. 1 = outputs registered on clk, giving 1-cycle latency.

Ports:
- clk  in  1  clock. Used only when REG_OUT=1.
- rst  in  1  synchronous, active-high reset. Used only when REG_OUT=1.
- i_valid  in  2  per-branch valid. Bit 1 = high branch, bit 0 = low branch.
- i_data_bus  in  2*DATA_WIDTH  [2*DATA_WIDTH-1:DATA_WIDTH] = high branch, [DATA_WIDTH-1:0] = low branch.
- i_en  in  1  mux enable.
- i_cmd  in  COMMMAND_WIDTH  select. 1 = high branch, 0 = low branch.
- o_valid  out  1  output valid.
- o_data_bus  out  DATA_WIDTH  selected data, or zero.

Behaviour:
- sel = i_cmd[0].
- Selected data: d_sel = i_data_bus[DATA_WIDTH +: DATA_WIDTH] when sel=1, otherwise i_data_bus[DATA_WIDTH-1:0].
- v_next = i_en & i_valid[sel].
- d_next = v_next ? d_sel : {DATA_WIDTH{1'b0}}. Output data is zeroed whenever the output is not valid, including disabled cycles and invalid selected branches.
- The valid bit of the non-selected branch has no effect.
- REG_OUT=0:
  - o_valid = v_next and o_data_bus = d_next, both combinational with zero latency.
  - clk and rst are unused; rst does not gate the outputs.
  - There is no internal state.
- REG_OUT=1:
  - On each rising clk edge, o_valid <= v_next and o_data_bus <= d_next. Latency is 1 cycle and there is no stall or backpressure.
  - When rst=1 at a clock edge: o_valid <= 0 and o_data_bus <= 0. Reset takes priority over data.
  - Reset value of every output is 0.
  - Reset asserted mid-stream drops the in-flight word, and the output is zero on the following cycle.
  - The first valid word after reset deassertion appears one cycle after it is sampled.
- X-free: with all inputs known, outputs must be known in both modes.
- No handshake (ready) exists. Consumers must sample o_valid every cycle (REG_OUT=1) or combinationally (REG_OUT=0).

Decomposition:
- No shared package is required. Do not redefine DATA_WIDTH/COMMMAND_WIDTH constants; they pass as parameters from the tree top.
- One natural sub-module: pipe_reg (a DATA_WIDTH+1 bit register with sync active-high clear).
  - Instantiated via generate only when REG_OUT=1.
  - Otherwise a direct assign is used.

Test Plan:
- Common setup (DATA_WIDTH=32, REG_OUT=0): i_data_bus={32'hFFFFFFFF, 32'hAAAAAAAA}.
- Disable: i_en=0, i_valid=2'b11, i_cmd=1 -> o_valid=0, o_data_bus=32'h0.
- Select high: i_en=1, i_valid=2'b10, i_cmd=1 -> o_valid=1, o_data_bus=32'hFFFFFFFF.
- Select low: i_en=1, i_valid=2'b01, i_cmd=0 -> o_valid=1, o_data_bus=32'hAAAAAAAA.
- Invalid selected branch, both directions -> o_valid=0, o_data_bus=0:
  - i_en=1, i_valid=2'b01, i_cmd=1.
  - i_en=1, i_valid=2'b10, i_cmd=0.
- Data change: i_data_bus={32'h0, 32'hFFFFFFFF}, i_valid=2'b01, i_cmd=0, i_en=1 -> o_valid=1, o_data_bus=32'hFFFFFFFF in the same delta (zero latency).
- REG_OUT=1:
  - Hold rst=1 for 2 cycles -> outputs 0.
  - Release rst and apply the select-high stimulus -> o_valid=1, o_data_bus=32'hFFFFFFFF exactly 1 cycle later.
  - Assert rst with the stimulus still valid -> outputs 0 after the next edge.
